// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parametrised serializer: FSM state encodings
// and the bit-counter width function.
package serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_SEND = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/param_serializer_ss_edge_detect.sv
// Registers slave-select and flags its falling and rising edges; the register
// resets high so a select already low at reset release never looks like a fall.
module ss_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic ss_i,
    output logic fall_o,
    output logic rise_o
);

    logic ss_q;

    // Previous-cycle copy of slave select
    always_ff @(posedge clock) begin
        if (reset) begin
            ss_q <= 1'b1;
        end else begin
            ss_q <= ss_i;
        end
    end

    assign fall_o = ss_q & ~ss_i;
    assign rise_o = ~ss_q & ss_i;

endmodule

// File: rtl/param_serializer.sv
// N-to-1 serial transmitter: accepts a word on valid/ready, waits for a falling
// ss edge, then shifts it out. Define SERIALIZER_PARITY_EN to append an even-parity bit.
module param_serializer
    import serializer_pkg::*;
#(
    parameter int   WIDTH      = 16,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0,
    localparam int  CW         = cnt_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_input,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             ss,
    output logic             data_output,
    output logic             busy,
    output logic             data_sent,
    output logic             aborted,
    output logic [1:0]       state_q,
    output logic [CW-1:0]    bit_count
);

`ifdef SERIALIZER_PARITY_EN
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif

    state_t           st_q, st_d;
    logic [WIDTH-1:0] shift_q, shift_d, shifted_s;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sent_q, sent_d;
    logic             abort_q, abort_d;
    logic             bit_s;
    logic             fall_s, rise_s;
`ifdef SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    ss_edge_detect u_ss_edge (
        .clock  (clock),
        .reset  (reset),
        .ss_i   (ss),
        .fall_o (fall_s),
        .rise_o (rise_s)
    );

    // Shift toward the output end with zero fill, and pick the outgoing bit
    always_comb begin
        shifted_s = shift_q;
        bit_s     = 1'b0;
        if (MSB_FIRST != 0) begin
            shifted_s = {shift_q[WIDTH-2:0], 1'b0};
            bit_s     = shift_q[WIDTH-1];
        end else begin
            shifted_s = {1'b0, shift_q[WIDTH-1:1]};
            bit_s     = shift_q[0];
        end
    end

    // Serial line: idle level outside SEND, parity bit on the extra final cycle
    always_comb begin
        data_output = IDLE_LEVEL;
        if (st_q == ST_SEND) begin
`ifdef SERIALIZER_PARITY_EN
            if (cnt_q == LAST_CNT) begin
                data_output = par_q;
            end else begin
                data_output = bit_s;
            end
`else
            data_output = bit_s;
`endif
        end else begin
            data_output = IDLE_LEVEL;
        end
    end

    // Next-state logic; an ss rise during SEND overrides completion
    always_comb begin
        st_d    = st_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        sent_d  = 1'b0;
        abort_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        case (st_q)
            ST_IDLE: begin
                if (data_valid) begin
                    shift_d = data_input;
`ifdef SERIALIZER_PARITY_EN
                    par_d   = ^data_input;
`endif
                    st_d    = ST_WAIT;
                end else begin
                    st_d    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (fall_s) begin
                    cnt_d = {CW{1'b0}};
                    st_d  = ST_SEND;
                end else begin
                    st_d  = ST_WAIT;
                end
            end
            ST_SEND: begin
                if (rise_s) begin
                    st_d    = ST_IDLE;
                    abort_d = 1'b1;
                    shift_d = {WIDTH{1'b0}};
                end else begin
                    shift_d = shifted_s;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        st_d   = ST_DONE;
                        sent_d = 1'b1;
                    end else begin
                        st_d   = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                st_d = ST_IDLE;
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and pulse registers
    always_ff @(posedge clock) begin
        if (reset) begin
            st_q    <= ST_IDLE;
            shift_q <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            sent_q  <= 1'b0;
            abort_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            st_q    <= st_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            abort_q <= abort_d;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign data_ready = (st_q == ST_IDLE);
    assign busy       = (st_q != ST_IDLE);
    assign data_sent  = sent_q;
    assign aborted    = abort_q;
    assign state_q    = st_q;
    assign bit_count  = cnt_q;

endmodule

// File: tb/tb_param_serializer.sv
// Directed bench: an MSB-first/idle-0 instance and an LSB-first/idle-1 instance
// share stimulus; each step compares against hand-derived expectations.
module tb_param_serializer;

    localparam int WIDTH = 16;
`ifdef SERIALIZER_PARITY_EN
    localparam int SEND_LEN = WIDTH + 1;
`else
    localparam int SEND_LEN = WIDTH;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dv;
    logic        ss;
    logic [15:0] din;

    logic        rdy_a, dout_a, busy_a, sent_a, abt_a;
    logic [1:0]  st_a;
    logic [4:0]  cnt_a;
    logic        rdy_b, dout_b, busy_b, sent_b, abt_b;
    logic [1:0]  st_b;
    logic [4:0]  cnt_b;

    int checks   = 0;
    int failures = 0;

    param_serializer #(.WIDTH(16), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clock(clk), .reset(rst), .data_input(din), .data_valid(dv), .data_ready(rdy_a),
        .ss(ss), .data_output(dout_a), .busy(busy_a), .data_sent(sent_a),
        .aborted(abt_a), .state_q(st_a), .bit_count(cnt_a)
    );

    param_serializer #(.WIDTH(16), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut_b (
        .clock(clk), .reset(rst), .data_input(din), .data_valid(dv), .data_ready(rdy_b),
        .ss(ss), .data_output(dout_b), .busy(busy_b), .data_sent(sent_b),
        .aborted(abt_b), .state_q(st_b), .bit_count(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] st, input logic pulse_sent,
                             input logic pulse_abort);
        chk({tag, "_st_a"}, 64'(st_a), 64'(st));
        chk({tag, "_st_b"}, 64'(st_b), 64'(st));
        chk({tag, "_rdy_a"}, 64'(rdy_a), 64'(st == 2'b00));
        chk({tag, "_busy_a"}, 64'(busy_a), 64'(st != 2'b00));
        chk({tag, "_sent_a"}, 64'(sent_a), 64'(pulse_sent));
        chk({tag, "_sent_b"}, 64'(sent_b), 64'(pulse_sent));
        chk({tag, "_abt_a"}, 64'(abt_a), 64'(pulse_abort));
        chk({tag, "_abt_b"}, 64'(abt_b), 64'(pulse_abort));
        if (st != 2'b10) begin
            chk({tag, "_idle_a"}, 64'(dout_a), 64'(1'b0));
            chk({tag, "_idle_b"}, 64'(dout_b), 64'(1'b1));
        end else begin
            chk({tag, "_insend"}, 64'(busy_b), 64'(1'b1));
        end
    endtask

    // Checks n SEND cycles starting at bit index 0; ticks once after each.
    task automatic check_bits(input string tag, input logic [15:0] w, input int n);
        logic ea, eb;
        for (int i = 0; i < n; i++) begin
            if (i < WIDTH) begin
                ea = w[WIDTH-1-i];
                eb = w[i];
            end else begin
                ea = ^w;
                eb = ^w;
            end
            chk($sformatf("%s_st%0d", tag, i), 64'(st_a), 64'(2'b10));
            chk($sformatf("%s_cnt%0d", tag, i), 64'(cnt_a), 64'(i));
            chk($sformatf("%s_a_bit%0d", tag, i), 64'(dout_a), 64'(ea));
            chk($sformatf("%s_b_bit%0d", tag, i), 64'(dout_b), 64'(eb));
            chk($sformatf("%s_nosent%0d", tag, i), 64'(sent_a), 64'(1'b0));
            tick();
        end
    endtask

    task automatic load(input logic [15:0] w);
        din = w;
        dv  = 1'b1;
        tick();
        dv  = 1'b0;
        din = 16'h0000;
        chk_state("load", 2'b01, 1'b0, 1'b0);
    endtask

    task automatic full_word(input string tag, input logic [15:0] w);
        check_bits(tag, w, SEND_LEN);
        chk_state({tag, "_done"}, 2'b11, 1'b1, 1'b0);
        tick();
        chk_state({tag, "_after"}, 2'b00, 1'b0, 1'b0);
        ss = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        dv  = 1'b0;
        ss  = 1'b1;
        din = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        chk_state("reset", 2'b00, 1'b0, 1'b0);
        chk("reset_cnt", 64'(cnt_a), 64'(0));

        // Normal transfer of A5C3
        load(16'hA5C3);
        ss = 1'b0;
        tick();
        full_word("a5c3", 16'hA5C3);

        // Single set bit: first for LSB-first, last for MSB-first
        load(16'h0001);
        ss = 1'b0;
        tick();
        full_word("w0001", 16'h0001);

        load(16'h0007);
        ss = 1'b0;
        tick();
        full_word("w0007", 16'h0007);

        // ss already low before the load: no edge, must stay in WAIT
        ss = 1'b0;
        tick();
        chk_state("sslow_idle", 2'b00, 1'b0, 1'b0);
        load(16'h3C96);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("sslow_wait", 2'b01, 1'b0, 1'b0);
        end
        ss = 1'b1;
        tick();
        chk_state("sshigh_wait", 2'b01, 1'b0, 1'b0);
        ss = 1'b0;
        tick();
        full_word("sslow", 16'h3C96);

        // Abort after 5 bits
        load(16'hFFFF);
        ss = 1'b0;
        tick();
        check_bits("abort", 16'hFFFF, 5);
        ss = 1'b1;
        tick();
        chk_state("abort_pulse", 2'b00, 1'b0, 1'b1);
        tick();
        chk_state("abort_after", 2'b00, 1'b0, 1'b0);

        // Reset during bit 8
        load(16'hA5C3);
        ss = 1'b0;
        tick();
        check_bits("rst", 16'hA5C3, 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_state("midrst", 2'b00, 1'b0, 1'b0);
        chk("midrst_cnt", 64'(cnt_a), 64'(0));
        tick();
        chk_state("midrst_after", 2'b00, 1'b0, 1'b0);
        ss = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
